// File: rtl/alu_exec_unit_if.sv
// Handshake bundle between the ALU reservation station (issue side) and the CDB (result side).
// master = RS/CDB side, slave = alu_exec_unit.
interface alu_exec_unit_if #(
   parameter int XLEN      = 32,
   parameter int ROB_WIDTH = 4
);
   logic                 in_valid;
   logic                 in_ready;
   logic [ROB_WIDTH-1:0] in_rob_id;
   logic [5:0]           in_op;
   logic [XLEN-1:0]      in_v1;
   logic [XLEN-1:0]      in_v2;
   logic                 out_valid;
   logic                 out_ready;
   logic [ROB_WIDTH-1:0] out_rob_id;
   logic [XLEN-1:0]      out_result;

   modport master (
      output in_valid, in_rob_id, in_op, in_v1, in_v2, out_ready,
      input  in_ready, out_valid, out_rob_id, out_result
   );

   modport slave (
      input  in_valid, in_rob_id, in_op, in_v1, in_v2, out_ready,
      output in_ready, out_valid, out_rob_id, out_result
   );
endinterface

// File: rtl/alu_exec_unit.sv
// Integer execution unit: single-cycle RV32I ALU and branch compare, result held until CDB grant.
// Define ALU_MUL_EN to add the iterative radix-2 RV32M multiplier (op[5:4]=10).
module alu_exec_unit #(
   parameter int  XLEN      = 32,
   parameter int  ROB_WIDTH = 4,
   localparam int SHAMT_W   = $clog2(XLEN)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           rdy,
   input  logic           flush,
   alu_exec_unit_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
`ifdef ALU_MUL_EN
      BUSY = 2'd1,
`endif
      DONE = 2'd2
   } state_t;

   state_t               state;
   logic                 out_valid_q;
   logic [ROB_WIDTH-1:0] out_rob_q;
   logic [XLEN-1:0]      out_result_q;

   logic                 accept;
   logic [2:0]           funct3;
   logic [SHAMT_W-1:0]   shamt;
   logic [XLEN-1:0]      sra_res;
   logic                 br_taken;
   logic [XLEN-1:0]      alu_result;

   assign bus.in_ready = rdy & ~flush &
                         ((state == IDLE) | ((state == DONE) & bus.out_ready));
   assign accept       = bus.in_valid & bus.in_ready;

   assign bus.out_valid  = out_valid_q;
   assign bus.out_rob_id = out_rob_q;
   assign bus.out_result = out_result_q;

   assign funct3  = bus.in_op[2:0];
   assign shamt   = bus.in_v2[SHAMT_W-1:0];
   // Kept as its own signal so an unsigned operand in a surrounding ?: cannot turn sra into srl.
   assign sra_res = $signed(bus.in_v1) >>> shamt;

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      br_taken = 1'b0;
      case (funct3)
         3'b000:  br_taken = (bus.in_v1 == bus.in_v2);
         3'b001:  br_taken = (bus.in_v1 != bus.in_v2);
         3'b100:  br_taken = ($signed(bus.in_v1) <  $signed(bus.in_v2));
         3'b101:  br_taken = ($signed(bus.in_v1) >= $signed(bus.in_v2));
         3'b110:  br_taken = (bus.in_v1 <  bus.in_v2);
         3'b111:  br_taken = (bus.in_v1 >= bus.in_v2);
         default: br_taken = 1'b0;
      endcase
   end

   always_comb begin
      alu_result = '0;
      case (bus.in_op[5:4])
         2'b00: begin
            case (funct3)
               3'b000:  alu_result = bus.in_op[3] ? bus.in_v1 - bus.in_v2 : bus.in_v1 + bus.in_v2;
               3'b001:  alu_result = bus.in_v1 << shamt;
               3'b010:  alu_result = {{(XLEN-1){1'b0}}, $signed(bus.in_v1) < $signed(bus.in_v2)};
               3'b011:  alu_result = {{(XLEN-1){1'b0}}, bus.in_v1 < bus.in_v2};
               3'b100:  alu_result = bus.in_v1 ^ bus.in_v2;
               3'b101:  alu_result = bus.in_op[3] ? sra_res : bus.in_v1 >> shamt;
               3'b110:  alu_result = bus.in_v1 | bus.in_v2;
               default: alu_result = bus.in_v1 & bus.in_v2;
            endcase
         end
         2'b01:   alu_result = {{(XLEN-1){1'b0}}, br_taken};
         default: alu_result = '0;
      endcase
   end

`ifdef ALU_MUL_EN
   // Magnitudes are multiplied unsigned; the sign is reapplied to the full 2*XLEN product.
   logic                 is_mul, a_neg, b_neg;
   logic [XLEN-1:0]      a_mag, b_mag;
   logic [2*XLEN-1:0]    mul_acc, mul_mcand, acc_next, prod;
   logic [XLEN-1:0]      mul_mplier, mul_result;
   logic [SHAMT_W-1:0]   mul_cnt;
   logic                 mul_neg, mul_high;

   assign is_mul   = (bus.in_op[5:4] == 2'b10);
   assign a_neg    = (bus.in_op[1:0] == 2'b01 || bus.in_op[1:0] == 2'b10) & bus.in_v1[XLEN-1];
   assign b_neg    = (bus.in_op[1:0] == 2'b01) & bus.in_v2[XLEN-1];
   assign a_mag    = a_neg ? -bus.in_v1 : bus.in_v1;
   assign b_mag    = b_neg ? -bus.in_v2 : bus.in_v2;
   assign acc_next = mul_acc + (mul_mplier[0] ? mul_mcand : '0);
   assign prod     = mul_neg ? -acc_next : acc_next;
   assign mul_result = mul_high ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
`endif

   // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
   // NOTE: multiplier datapath registers are not reset; they are always loaded before use.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state        <= IDLE;
         out_valid_q  <= 1'b0;
         out_rob_q    <= '0;
         out_result_q <= '0;
`ifdef ALU_MUL_EN
         mul_cnt      <= '0;
`endif
      end else if (rdy) begin
         if (flush) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
         end else if (accept) begin
            out_rob_q <= bus.in_rob_id;
`ifdef ALU_MUL_EN
            if (is_mul) begin
               state       <= BUSY;
               out_valid_q <= 1'b0;
               mul_acc     <= '0;
               mul_mcand   <= {{XLEN{1'b0}}, a_mag};
               mul_mplier  <= b_mag;
               mul_neg     <= a_neg ^ b_neg;
               mul_high    <= (bus.in_op[1:0] != 2'b00);
               mul_cnt     <= '0;
            end else
`endif
            begin
               state        <= DONE;
               out_valid_q  <= 1'b1;
               out_result_q <= alu_result;
            end
         end else if (state == DONE && bus.out_ready) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
         end
`ifdef ALU_MUL_EN
         else if (state == BUSY) begin
            mul_acc    <= acc_next;
            mul_mcand  <= mul_mcand << 1;
            mul_mplier <= mul_mplier >> 1;
            mul_cnt    <= mul_cnt + 1'b1;
            if (mul_cnt == SHAMT_W'(XLEN - 1)) begin
               state        <= DONE;
               out_valid_q  <= 1'b1;
               out_result_q <= mul_result;
            end
         end
`endif
      end
   end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: expected results queued on accept, compared on CDB grant.
// Build with +define+ALU_MUL_EN to exercise the multiplier.
module tb_alu_exec_unit;

   localparam int XLEN = 32;
   localparam int RW   = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic rdy = 1'b0;
   logic flush = 1'b0;

   alu_exec_unit_if #(.XLEN(XLEN), .ROB_WIDTH(RW)) bus ();

   alu_exec_unit #(.XLEN(XLEN), .ROB_WIDTH(RW)) dut (
      .clk   (clk),
      .rst   (rst),
      .rdy   (rdy),
      .flush (flush),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   typedef struct packed {
      logic [RW-1:0]   rob;
      logic [XLEN-1:0] res;
   } exp_t;

   exp_t exp_q[$];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] model(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [4:0]  sh;
      logic [31:0] r;
      logic [63:0] p;
      sh = b[4:0];
      r  = 32'd0;
      p  = 64'd0;
      case (op[5:4])
         2'b00: case (op[2:0])
            3'd0: r = op[3] ? a - b : a + b;
            3'd1: r = a << sh;
            3'd2: r = {31'd0, $signed(a) < $signed(b)};
            3'd3: r = {31'd0, a < b};
            3'd4: r = a ^ b;
            3'd5: begin
               if (op[3]) begin
                  p = {{32{a[31]}}, a} >> sh;
                  r = p[31:0];
               end else r = a >> sh;
            end
            3'd6: r = a | b;
            default: r = a & b;
         endcase
         2'b01: case (op[2:0])
            3'd0: r = {31'd0, a == b};
            3'd1: r = {31'd0, a != b};
            3'd4: r = {31'd0, $signed(a) <  $signed(b)};
            3'd5: r = {31'd0, $signed(a) >= $signed(b)};
            3'd6: r = {31'd0, a <  b};
            3'd7: r = {31'd0, a >= b};
            default: r = 32'd0;
         endcase
`ifdef ALU_MUL_EN
         2'b10: begin
            case (op[1:0])
               2'b00: p = {32'd0, a} * {32'd0, b};
               2'b01: p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
               2'b10: p = {{32{a[31]}}, a} * {32'd0, b};
               default: p = {32'd0, a} * {32'd0, b};
            endcase
            r = (op[1:0] == 2'b00) ? p[31:0] : p[63:32];
         end
`endif
         default: r = 32'd0;
      endcase
      return r;
   endfunction

   // Scoreboard: grant pops (before the edge), accept pushes; flush and reset discard pending work.
   always @(negedge clk) begin
      exp_t e;
      if (!rst) exp_q.delete();
      else if (rdy) begin
         if (flush) exp_q.delete();
         else begin
            if (bus.out_valid && bus.out_ready) begin
               if (exp_q.size() == 0) check("sb_unexpected_out", 64'(exp_q.size()), 64'd1);
               else begin
                  e = exp_q.pop_front();
                  check("sb_rob", 64'(bus.out_rob_id), 64'(e.rob));
                  check("sb_result", 64'(bus.out_result), 64'(e.res));
               end
            end
            if (bus.in_valid && bus.in_ready) begin
               e.rob = bus.in_rob_id;
               e.res = model(bus.in_op, bus.in_v1, bus.in_v2);
               exp_q.push_back(e);
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [RW-1:0] rob, input logic [5:0] op,
                        input logic [31:0] a, input logic [31:0] b, output int waited);
      bus.in_valid  = 1'b1;
      bus.in_rob_id = rob;
      bus.in_op     = op;
      bus.in_v1     = a;
      bus.in_v2     = b;
      waited = 0;
      @(negedge clk);
      while (!bus.in_ready && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      if (!bus.in_ready) check("accept_timeout", 64'(waited), 64'd0);
      step();
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_valid(input int stall_at, output int lat, output int ready_leak);
      lat = 0;
      ready_leak = 0;
      while (!bus.out_valid && lat < 200) begin
         if (bus.in_ready) ready_leak++;
         if (lat == stall_at) rdy = 1'b0;
         if (lat == stall_at + 3) rdy = 1'b1;
         step();
         lat++;
      end
      rdy = 1'b1;
   endtask

   task automatic grant();
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
   endtask

   function automatic logic [31:0] pick_val();
      case ($urandom_range(0, 5))
         0: return 32'h0000_0000;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'h7FFF_FFFF;
         default: return $urandom();
      endcase
   endfunction

   initial begin
      int w, lat, leak, rises;
      logic [31:0] held;
      bit done;

      bus.in_valid = 1'b0; bus.in_rob_id = '0; bus.in_op = '0;
      bus.in_v1 = '0; bus.in_v2 = '0; bus.out_ready = 1'b0;

      step(); step();
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_out_rob", 64'(bus.out_rob_id), 64'd0);
      check("rst_out_result", 64'(bus.out_result), 64'd0);
      rst = 1'b1;
      rdy = 1'b1;
      #1;
      check("idle_in_ready", 64'(bus.in_ready), 64'd1);

      // add -1 + 1, then hold five cycles without grant
      issue(4'd3, 6'b000000, 32'hFFFF_FFFF, 32'd1, w);
      check("add_valid", 64'(bus.out_valid), 64'd1);
      check("add_rob", 64'(bus.out_rob_id), 64'd3);
      check("add_result", 64'(bus.out_result), 64'd0);
      bus.in_valid = 1'b1; bus.in_rob_id = 4'd4; bus.in_op = 6'b000000;
      held = bus.out_result;
      for (int i = 0; i < 5; i++) begin
         check("hold_in_ready", 64'(bus.in_ready), 64'd0);
         step();
         check("hold_valid", 64'(bus.out_valid), 64'd1);
         check("hold_rob", 64'(bus.out_rob_id), 64'd3);
         check("hold_result", 64'(bus.out_result), 64'(held));
      end
      bus.in_valid = 1'b0;
      grant();
      check("grant_to_idle", 64'(bus.out_valid), 64'd0);

      issue(4'd5, 6'b001101, 32'h8000_0000, 32'h24, w);
      check("sra_result", 64'(bus.out_result), 64'hF800_0000);
      grant();
      issue(4'd6, 6'b010100, 32'hFFFF_FFFE, 32'd1, w);
      check("blt_result", 64'(bus.out_result), 64'd1);
      grant();
      issue(4'd7, 6'b010110, 32'hFFFF_FFFE, 32'd1, w);
      check("bltu_result", 64'(bus.out_result), 64'd0);
      grant();
      issue(4'd8, 6'b110000, 32'd5, 32'd6, w);
      check("reserved_result", 64'(bus.out_result), 64'd0);
      grant();

      // back-to-back with out_ready held high
      bus.out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         issue(4'(k + 1), 6'b000000, 32'(k * 7), 32'd100, w);
         check("b2b_wait", 64'(w), 64'd0);
         check("b2b_rob", 64'(bus.out_rob_id), 64'(k + 1));
      end
      step();
      check("b2b_drained", 64'(bus.out_valid), 64'd0);
      bus.out_ready = 1'b0;

`ifdef ALU_MUL_EN
      issue(4'd9, 6'b100001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, w);
      wait_valid(-10, lat, leak);
      check("mulh_latency", 64'(lat), 64'd32);
      check("mulh_busy_ready", 64'(leak), 64'd0);
      check("mulh_result", 64'(bus.out_result), 64'h0000_0000);
      grant();
      issue(4'd10, 6'b100011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, w);
      wait_valid(10, lat, leak);
      check("mulhu_stall_latency", 64'(lat), 64'd35);
      check("mulhu_busy_ready", 64'(leak), 64'd0);
      check("mulhu_result", 64'(bus.out_result), 64'hFFFF_FFFE);
      grant();

      // flush in the 10th BUSY cycle
      issue(4'd11, 6'b100011, 32'h1234_5678, 32'h9ABC_DEF0, w);
      for (int i = 0; i < 9; i++) step();
      flush = 1'b1;
      step();
      flush = 1'b0;
      check("mflush_valid", 64'(bus.out_valid), 64'd0);
      check("mflush_in_ready", 64'(bus.in_ready), 64'd1);
      rises = 0;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 40; i++) begin
         step();
         if (bus.out_valid) rises++;
      end
      bus.out_ready = 1'b0;
      check("mflush_no_result", 64'(rises), 64'd0);
      issue(4'd12, 6'b100000, 32'hFFFF_FFFD, 32'd3, w);
      check("post_flush_wait", 64'(w), 64'd0);
      wait_valid(-10, lat, leak);
      check("mul_result", 64'(bus.out_result), 64'hFFFF_FFF7);
      grant();
`else
      issue(4'd9, 6'b100001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, w);
      check("mulclass_result", 64'(bus.out_result), 64'd0);
      check("mulclass_valid", 64'(bus.out_valid), 64'd1);
      grant();
`endif

      // flush of a held single-cycle result
      issue(4'd13, 6'b000000, 32'd1, 32'd2, w);
      flush = 1'b1;
      step();
      flush = 1'b0;
      check("flush_valid", 64'(bus.out_valid), 64'd0);

      // random traffic with random CDB grants
      done = 1'b0;
      fork
         begin
            for (int n = 0; n < 60; n++) begin
               logic [5:0] op;
               int r;
               r = $urandom_range(0, 9);
               op = 6'($urandom());
               if (r <= 5)      op[5:4] = 2'b00;
               else if (r <= 7) op[5:4] = 2'b01;
               else if (r == 8) op[5:4] = 2'b11;
               else             op[5:4] = 2'b10;
               issue(4'($urandom()), op, pick_val(), pick_val(), w);
            end
            done = 1'b1;
         end
         begin
            while (!done) begin
               step();
               bus.out_ready = 1'($urandom_range(0, 1));
            end
         end
      join
      bus.out_ready = 1'b1;
      for (int i = 0; i < 40 && bus.out_valid; i++) step();
      bus.out_ready = 1'b0;

      // reset while a result is held
      issue(4'd5, 6'b000000, 32'd5, 32'd6, w);
      check("pre_rst_result", 64'(bus.out_result), 64'd11);
      rst = 1'b0;
      step();
      check("mid_rst_valid", 64'(bus.out_valid), 64'd0);
      check("mid_rst_rob", 64'(bus.out_rob_id), 64'd0);
      check("mid_rst_result", 64'(bus.out_result), 64'd0);
      rst = 1'b1;
      #1;
      check("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
      step();

      check("sb_drain", 64'(exp_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Parametrised integer execution unit for the out-of-order core. It sits between the ALU reservation station and the common data bus (CDB), and accepts one tagged operation per handshake. Results are held in an output register until the CDB grants them. Branch compares and RV32I arithmetic/logic complete in one cycle. An optional iterative multiplier adds the RV32M multiply ops. A pipeline flush discards in-flight work.

## Interface
Parameters:
- XLEN, 32: operand/result width; power of two, ≥8.
- ROB_WIDTH, 4: ROB tag width.
- SHAMT_W, $clog2(XLEN): shift-amount width; derived, not overridden.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-low.
- rdy  in  1  global enable; when low, all state frozen and in_ready forced low.
- flush  in  1  misprediction flush; synchronous.
- in_valid  in  1  RS presents an op.
- in_ready  out  1  unit can accept this cycle.
- in_rob_id  in  ROB_WIDTH  tag of op.
- in_op  in  6  op code: [5] mul class, [4] branch class, [3] alt (sub/sra), [2:0] funct3.
- in_v1, in_v2  in  XLEN  operands.
- out_valid  out  1  result register holds a valid result.
- out_ready  in  1  CDB grant.
- out_rob_id  out  ROB_WIDTH  tag of held result.
- out_result  out  XLEN  result; branch class gives 0/1 in bit 0, upper bits 0.

## Operation
- States: IDLE, BUSY (multiply only), DONE.
- in_ready = rdy & !flush & (IDLE | (DONE & out_ready)). An op is accepted on an edge where in_valid & in_ready.
- Accepting a single-cycle op loads the result register and moves to DONE.
- Accepting a mul op loads the multiplier and moves to BUSY.
- In DONE, out_ready without a new accept moves to IDLE. out_ready with a new accept does back-to-back replacement, so throughput is one op/cycle.
- Arithmetic, op[5:4]=00, selected by funct3:
  - 000: add, or sub if op[3].
  - 001: sll.
  - 010: slt (signed).
  - 011: sltu.
  - 100: xor.
  - 101: srl, or sra if op[3].
  - 110: or.
  - 111: and.
  - Shifts use in_v2[SHAMT_W-1:0]. All arithmetic is modulo 2^XLEN.
- Branch, op[5:4]=01, selected by funct3:
  - 000 eq, 001 ne, 100 lt, 101 ge, 110 ltu, 111 geu.
  - 010 and 011 give result 0.
- op[5:4]=11 is reserved and gives result 0 in one cycle.
- flush: next state IDLE, out_valid low, any BUSY work discarded. flush has priority over accept and over out_ready.
- rst low: state IDLE; out_valid 0, out_rob_id 0, out_result 0, multiplier counter 0. rst has priority over rdy and flush.

## Timing
- Single-cycle op accepted at edge N: out_valid high after edge N, with result and tag stable.
- out_valid stays high, and out_result/out_rob_id stay unchanged, until the edge where out_ready is high.
- Multiply accepted at edge N: BUSY for XLEN cycles, then DONE after edge N+XLEN. in_ready is low throughout BUSY.
- rdy low freezes the counter, state and outputs. The effective latency extends by the number of stalled cycles.
- out_ready while out_valid is low is ignored.

## Configuration
- ALU_MUL_EN defined: op[5:4]=10 is the multiply class, selected by op[1:0]:
  - 00 mul (low XLEN bits).
  - 01 mulh (signed×signed).
  - 10 mulhsu (signed×unsigned).
  - 11 mulhu.
  - Radix-2 shift-add over the 2·XLEN product, operands sign-corrected per op, XLEN iterations.
- ALU_MUL_EN undefined: no BUSY state and no multiplier logic. op[5:4]=10 gives result 0 in one cycle, like reserved ops.

## Test plan
- Default params, in_op=000000, v1=0xFFFFFFFF, v2=1, rob_id=3 -> out_result=0, out_rob_id=3, out_valid one edge after accept. Then op=001101 (sra), v1=0x80000000, v2=0x24 -> shamt 4, result 0xF8000000.
- Branch class, op=010100 (blt), v1=0xFFFFFFFE, v2=1 -> result 1. Then op=010110 (bltu) with the same operands -> result 0.
- Back-to-back: in_valid held high for 4 ops, out_ready held high -> 4 results on consecutive cycles, tags in order. With out_ready low -> in_ready low, and the first result is held unchanged for 5 cycles.
- ALU_MUL_EN: mulh, v1=0xFFFFFFFF, v2=0xFFFFFFFF -> 0x00000000. mulhu with the same operands -> 0xFFFFFFFE. Both valid exactly 32 cycles after accept; in_ready low while BUSY. Repeat with rdy low for 3 cycles mid-multiply -> latency 35.
- flush asserted at the 10th BUSY cycle -> IDLE next edge, out_valid never rises for that tag. Next op is accepted immediately.
- rst low mid-DONE with out_ready low -> all outputs 0 after the edge, in_ready high once rst is high.
